// File: rtl/ysyx_23060061_key_lut_pkg.sv
// Shared constants for the key lookup table.
// Also holds the index-width helper that the table and the match logic both use.
package ysyx_23060061_key_lut_pkg;

    localparam int PRIO_OR      = 0;
    localparam int PRIO_LOW_IDX = 1;

    // A single-entry table still needs a one-bit index port.
    function automatic int idxWidth(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ysyx_23060061_key_match.sv
// Combinational key compare across all table entries.
// Produces the hit and multi-hit flags, the lowest hitting index and the merged data.
module ysyx_23060061_key_match
    import ysyx_23060061_key_lut_pkg::*;
#(
    parameter int NR_KEY    = 4,
    parameter int KEY_LEN   = 8,
    parameter int DATA_LEN  = 32,
    parameter int PRIO_MODE = PRIO_LOW_IDX,
    localparam int IDX_W    = idxWidth(NR_KEY)
) (
    input  logic [NR_KEY-1:0]               i_valid,
    input  logic [NR_KEY-1:0][KEY_LEN-1:0]  i_keys,
    input  logic [NR_KEY-1:0][DATA_LEN-1:0] i_data,
    input  logic [KEY_LEN-1:0]              i_req_key,
    output logic                            o_hit,
    output logic                            o_multi,
    output logic [IDX_W-1:0]                o_idx,
    output logic [DATA_LEN-1:0]             o_data
);

    logic [NR_KEY-1:0]   w_match;
    logic [DATA_LEN-1:0] w_low_data;
    logic [DATA_LEN-1:0] w_or_data;

    // Scan from the top down so the last assignment is the lowest hitting index.
    always_comb begin
        w_match    = '0;
        w_low_data = '0;
        w_or_data  = '0;
        o_idx      = '0;
        for (int i = NR_KEY - 1; i >= 0; i--) begin
            w_match[i] = i_valid[i] && (i_keys[i] == i_req_key);
            if (w_match[i]) begin
                o_idx      = IDX_W'(i);
                w_low_data = i_data[i];
                w_or_data  = w_or_data | i_data[i];
            end
        end
    end

    assign o_hit   = |w_match;
    assign o_multi = |(w_match & (w_match - NR_KEY'(1)));
    assign o_data  = (PRIO_MODE == PRIO_LOW_IDX) ? w_low_data : w_or_data;

endmodule

// File: rtl/ysyx_23060061_key_lut.sv
// Small associative key/data table with a one-deep registered lookup response.
// Lookups see the table as it was before any same-cycle write, invalidate or clear.
module ysyx_23060061_key_lut
    import ysyx_23060061_key_lut_pkg::*;
#(
    parameter int NR_KEY      = 4,
    parameter int KEY_LEN     = 8,
    parameter int DATA_LEN    = 32,
    parameter int HAS_DEFAULT = 0,
    parameter int PRIO_MODE   = PRIO_LOW_IDX,
    localparam int IDX_W      = idxWidth(NR_KEY)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                wr_en,
    input  logic [IDX_W-1:0]    wr_idx,
    input  logic [KEY_LEN-1:0]  wr_key,
    input  logic [DATA_LEN-1:0] wr_data,
    input  logic                inv_en,
    input  logic [IDX_W-1:0]    inv_idx,
    input  logic                clr_all,
    input  logic [DATA_LEN-1:0] default_out,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [KEY_LEN-1:0]  req_key,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_LEN-1:0] rsp_data,
    output logic                rsp_hit,
    output logic                rsp_multi,
    output logic [IDX_W-1:0]    rsp_idx
);

    logic [NR_KEY-1:0]               r_valid;
    logic [NR_KEY-1:0][KEY_LEN-1:0]  r_key;
    logic [NR_KEY-1:0][DATA_LEN-1:0] r_data;

    logic                r_rsp_valid;
    logic [DATA_LEN-1:0] r_rsp_data;
    logic                r_rsp_hit;
    logic                r_rsp_multi;
    logic [IDX_W-1:0]    r_rsp_idx;

    logic                w_wr_ok;
    logic                w_inv_ok;
    logic                w_accept;
    logic                w_hit;
    logic                w_multi;
    logic [IDX_W-1:0]    w_idx;
    logic [DATA_LEN-1:0] w_hit_data;

    // Out-of-range indices only exist when NR_KEY is not a power of two.
    if ((2 ** IDX_W) == NR_KEY) begin : g_pow2
        assign w_wr_ok  = 1'b1;
        assign w_inv_ok = 1'b1;
    end else begin : g_npow2
        assign w_wr_ok  = (wr_idx < IDX_W'(NR_KEY));
        assign w_inv_ok = (inv_idx < IDX_W'(NR_KEY));
    end

    // Write is applied after invalidate so a same-index write leaves the entry valid.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid <= '0;
        end else if (clr_all) begin
            r_valid <= '0;
        end else begin
            if (inv_en && w_inv_ok) r_valid[inv_idx] <= 1'b0;
            if (wr_en && w_wr_ok)   r_valid[wr_idx]  <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en && w_wr_ok) begin
            r_key[wr_idx]  <= wr_key;
            r_data[wr_idx] <= wr_data;
        end
    end

    ysyx_23060061_key_match #(
        .NR_KEY    (NR_KEY),
        .KEY_LEN   (KEY_LEN),
        .DATA_LEN  (DATA_LEN),
        .PRIO_MODE (PRIO_MODE)
    ) u_match (
        .i_valid   (r_valid),
        .i_keys    (r_key),
        .i_data    (r_data),
        .i_req_key (req_key),
        .o_hit     (w_hit),
        .o_multi   (w_multi),
        .o_idx     (w_idx),
        .o_data    (w_hit_data)
    );

    assign req_ready = !r_rsp_valid || rsp_ready;
    assign w_accept  = req_valid && req_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_hit   <= 1'b0;
            r_rsp_multi <= 1'b0;
            r_rsp_idx   <= '0;
        end else if (w_accept) begin
            r_rsp_valid <= 1'b1;
            r_rsp_hit   <= w_hit;
            r_rsp_multi <= w_multi;
            r_rsp_idx   <= w_idx;
            if (w_hit)                 r_rsp_data <= w_hit_data;
            else if (HAS_DEFAULT != 0) r_rsp_data <= default_out;
            else                       r_rsp_data <= '0;
        end else if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign rsp_hit   = r_rsp_hit;
    assign rsp_multi = r_rsp_multi;
    assign rsp_idx   = r_rsp_idx;

endmodule
